hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 32 +++
 rtl/hazard_scoreboard_if.sv | 44 ++++
 rtl/hazard_scoreboard_hazard_cmp.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: register ids, Tnew/Tuse encodings,
// mul/div latencies and the forwarding-select encoding.
package hazard_scoreboard_pkg;

   localparam int REG_W       = 5;
   localparam int STAGES_DEF  = 3;
   localparam int TNEW_W_DEF  = 2;
   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;

   typedef logic [REG_W-1:0] reg_t;

   // Cycles until a result exists (Tnew) or is needed (Tuse)
   typedef enum logic [TNEW_W_DEF-1:0] {
      T_NOW   = 2'd0,
      T_ONE   = 2'd1,
      T_TWO   = 2'd2,
      T_THREE = 2'd3
   } tcyc_e;

   typedef enum logic [1:0] {
      FWD_RF = 2'd0,
      FWD_E  = 2'd1,
      FWD_M  = 2'd2,
      FWD_W  = 2'd3
   } fwd_sel_e;

   function automatic int max_lat(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decoder and the hazard scoreboard.
interface hazard_scoreboard_if #(
   parameter int TNEW_W = 2,
   parameter int SEL_W  = 2
);
   import hazard_scoreboard_pkg::*;

   logic              d_valid;
   reg_t              d_rs;
   reg_t              d_rt;
   logic [TNEW_W-1:0] d_tuse_rs;
   logic [TNEW_W-1:0] d_tuse_rt;
   reg_t              d_dst;
   logic [TNEW_W-1:0] d_tnew;
   logic              d_md_start;
   logic              d_md_is_div;
   logic              d_md_use;
   logic              flush;
   logic              stall;
   logic [SEL_W-1:0]  fwd_sel_rs;
   logic [SEL_W-1:0]  fwd_sel_rt;
   logic              md_busy;

   modport master (
      output d_valid, d_rs, d_rt,
      output d_tuse_rs, d_tuse_rt,
      output d_dst, d_tnew,
      output d_md_start, d_md_is_div,
      output d_md_use, flush,
      input  stall, fwd_sel_rs,
      input  fwd_sel_rt, md_busy
   );

   modport slave (
      input  d_valid, d_rs, d_rt,
      input  d_tuse_rs, d_tuse_rt,
      input  d_dst, d_tnew,
      input  d_md_start, d_md_is_div,
      input  d_md_use, flush,
      output stall, fwd_sel_rs,
      output fwd_sel_rt, md_busy
   );

endinterface

// File: rtl/hazard_scoreboard_hazard_cmp.sv
// Per-source hazard check: finds the youngest in-flight writer of a
// source register and decides between stalling and forwarding.
module hazard_cmp
   import hazard_scoreboard_pkg::*;
#(
   parameter int STAGES = 3,
   parameter int TNEW_W = 2,
   parameter int SEL_W  = 2
) (
   input  logic [STAGES-1:0][REG_W-1:0]  ent_dst,
   input  logic [STAGES-1:0][TNEW_W-1:0] ent_tnew,
   input  reg_t                          src,
   input  logic [TNEW_W-1:0]             tuse,
   output logic                          hazard,
   output logic [SEL_W-1:0]              fwd_sel
);

   logic              hit;
   logic [SEL_W-1:0]  hit_idx;
   logic [TNEW_W-1:0] hit_tnew;

   // Walk oldest to youngest so the youngest match overwrites
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_tnew = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (src != '0 && ent_dst[k] == src) begin
            hit      = 1'b1;
            hit_idx  = SEL_W'(k + 1);
            hit_tnew = ent_tnew[k];
         end
      end
   end

   always_comb begin
      hazard  = hit && (hit_tnew > tuse);
      fwd_sel = '0;
      if (hit && hit_tnew == '0) begin
         fwd_sel = hit_idx;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard for E/M/W plus the mul/div busy counter;
// drives decode stall and per-source forwarding selects.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int STAGES  = STAGES_DEF,
   parameter int TNEW_W  = TNEW_W_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);

   localparam int SEL_W = $clog2(STAGES + 1);
   localparam int CNT_W = $clog2(max_lat(MUL_LAT, DIV_LAT) + 1);

   logic [STAGES-1:0][REG_W-1:0]  dst_q, dst_d;
   logic [STAGES-1:0][TNEW_W-1:0] tnew_q, tnew_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;

   logic             haz_rs, haz_rt, haz_md;
   logic             stall, accept, md_busy;
   logic [SEL_W-1:0] sel_rs, sel_rt;

   hazard_cmp #(
      .STAGES (STAGES),
      .TNEW_W (TNEW_W),
      .SEL_W  (SEL_W)
   ) u_cmp_rs (
      .ent_dst  (dst_q),
      .ent_tnew (tnew_q),
      .src      (bus.d_rs),
      .tuse     (bus.d_tuse_rs),
      .hazard   (haz_rs),
      .fwd_sel  (sel_rs)
   );

   hazard_cmp #(
      .STAGES (STAGES),
      .TNEW_W (TNEW_W),
      .SEL_W  (SEL_W)
   ) u_cmp_rt (
      .ent_dst  (dst_q),
      .ent_tnew (tnew_q),
      .src      (bus.d_rt),
      .tuse     (bus.d_tuse_rt),
      .hazard   (haz_rt),
      .fwd_sel  (sel_rt)
   );

   // A start also claims the unit, so back-to-back starts serialise
   always_comb begin
      md_busy = (cnt_q != '0);
      haz_md  = (bus.d_md_use || bus.d_md_start) && md_busy;
      stall   = bus.d_valid && (haz_rs || haz_rt || haz_md);
      accept  = bus.d_valid && !stall && !bus.flush;
   end

   always_comb begin
      dst_d  = '0;
      tnew_d = '0;
      for (int k = 1; k < STAGES; k++) begin
         dst_d[k]  = dst_q[k-1];
         tnew_d[k] = (tnew_q[k-1] != '0) ? tnew_q[k-1] - 1'b1 : '0;
      end
      if (accept) begin
         dst_d[0]  = bus.d_dst;
         tnew_d[0] = bus.d_tnew;
      end
      if (bus.flush) begin
         dst_d  = '0;
         tnew_d = '0;
      end
   end

   // Flush deliberately leaves the mul/div unit running
   always_comb begin
      cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
      if (accept && bus.d_md_start) begin
         cnt_d = bus.d_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dst_q  <= '0;
         tnew_q <= '0;
         cnt_q  <= '0;
      end else begin
         dst_q  <= dst_d;
         tnew_q <= tnew_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.stall      = stall;
   assign bus.fwd_sel_rs = sel_rs;
   assign bus.fwd_sel_rt = sel_rt;
   assign bus.md_busy    = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stalls, forwarding, mul/div
// busy window, flush and asynchronous reset.
module tb_hazard_scoreboard;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   hazard_scoreboard_if #(.TNEW_W(2), .SEL_W(2)) bus ();

   hazard_scoreboard #(
      .STAGES  (3),
      .TNEW_W  (2),
      .MUL_LAT (5),
      .DIV_LAT (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic       v,
                      input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic [1:0] urs,
                      input logic [1:0] urt,
                      input logic [4:0] dst,
                      input logic [1:0] tn,
                      input logic       st,
                      input logic       dv,
                      input logic       use_md,
                      input logic       fl);
      bus.d_valid     = v;
      bus.d_rs        = rs;
      bus.d_rt        = rt;
      bus.d_tuse_rs   = urs;
      bus.d_tuse_rt   = urt;
      bus.d_dst       = dst;
      bus.d_tnew      = tn;
      bus.d_md_start  = st;
      bus.d_md_is_div = dv;
      bus.d_md_use    = use_md;
      bus.flush       = fl;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      drv(1, 3, 3, 0, 0, 3, 2, 0, 0, 1, 0);
      #12;
      chk("rst_stall", 32'(bus.stall), 0);
      chk("rst_fwd_rs", 32'(bus.fwd_sel_rs), 0);
      chk("rst_fwd_rt", 32'(bus.fwd_sel_rt), 0);
      chk("rst_busy", 32'(bus.md_busy), 0);
      idle();
      #1 reset = 1'b1;
      tick();

      // producer dst=8 tnew=2, consumer rs=8 tuse=0
      drv(1, 0, 0, 0, 0, 8, 2, 0, 0, 0, 0);
      #1 chk("p8_issue_stall", 32'(bus.stall), 0);
      tick();
      drv(1, 8, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      #1 chk("raw_c1_stall", 32'(bus.stall), 1);
      chk("raw_c1_fwd", 32'(bus.fwd_sel_rs), 0);
      tick();
      #1 chk("raw_c2_stall", 32'(bus.stall), 1);
      tick();
      #1 chk("raw_c3_stall", 32'(bus.stall), 0);
      chk("raw_c3_fwd_w", 32'(bus.fwd_sel_rs), 3);
      tick();

      // E={5,1}: tuse equal to tnew is fine, smaller stalls
      drv(1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("e5_rt_stall", 32'(bus.stall), 1);
      chk("e5_rs_nofwd", 32'(bus.fwd_sel_rs), 0);
      idle();
      tick();
      drv(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("m5_stall", 32'(bus.stall), 0);
      chk("m5_fwd_m", 32'(bus.fwd_sel_rs), 2);
      idle();
      repeat (3) tick();

      // two writers of r8: youngest (E) wins
      drv(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0);
      tick();
      drv(1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0);
      tick();
      drv(1, 0, 8, 0, 1, 0, 0, 0, 0, 0, 0);
      #1 chk("young_stall", 32'(bus.stall), 0);
      chk("young_fwd_rt", 32'(bus.fwd_sel_rt), 1);
      chk("young_fwd_rs", 32'(bus.fwd_sel_rs), 0);
      tick();

      // $0 is never a hazard
      drv(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
      tick();
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("r0_stall", 32'(bus.stall), 0);
      chk("r0_fwd", 32'(bus.fwd_sel_rs), 0);
      idle();
      repeat (3) tick();

      // divide: busy exactly 10 cycles
      drv(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      #1 chk("div_start_busy", 32'(bus.md_busy), 0);
      chk("div_start_stall", 32'(bus.stall), 0);
      tick();
      for (int i = 1; i <= 10; i++) begin
         if (i == 3) drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         else        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         #1 chk($sformatf("div_busy_%0d", i), 32'(bus.md_busy), 1);
         chk($sformatf("div_stall_%0d", i), 32'(bus.stall), 1);
         tick();
      end
      drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      #1 chk("div_done_busy", 32'(bus.md_busy), 0);
      chk("div_done_stall", 32'(bus.stall), 0);
      tick();

      // multiply accepted above: busy 5 cycles
      for (int i = 1; i <= 6; i++) begin
         idle();
         #1 chk($sformatf("mul_busy_%0d", i),
                32'(bus.md_busy), (i <= 5) ? 1 : 0);
         tick();
      end

      // flush while stalled on E={9,1}; divide keeps counting
      drv(1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 0);
      #1 chk("f_issue_stall", 32'(bus.stall), 0);
      tick();
      drv(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1 chk("f_pre_stall", 32'(bus.stall), 1);
      chk("f_pre_busy", 32'(bus.md_busy), 1);
      tick();
      drv(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("f_post_stall", 32'(bus.stall), 0);
      chk("f_post_fwd", 32'(bus.fwd_sel_rs), 0);
      chk("f_post_busy", 32'(bus.md_busy), 1);
      tick();
      for (int i = 3; i <= 6; i++) begin
         if (i == 5) drv(1, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0);
         else        idle();
         #1 chk($sformatf("f_busy_%0d", i), 32'(bus.md_busy), 1);
         tick();
      end

      // count is 4 here: async reset clears outputs before next edge
      drv(1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("ar_pre_stall", 32'(bus.stall), 1);
      chk("ar_pre_fwd", 32'(bus.fwd_sel_rs), 2);
      chk("ar_pre_busy", 32'(bus.md_busy), 1);
      #1 reset = 1'b0;
      #1 chk("ar_busy", 32'(bus.md_busy), 0);
      chk("ar_stall", 32'(bus.stall), 0);
      chk("ar_fwd_rs", 32'(bus.fwd_sel_rs), 0);
      chk("ar_fwd_rt", 32'(bus.fwd_sel_rt), 0);
      #1 reset = 1'b1;
      idle();
      repeat (2) tick();
      chk("post_rst_busy", 32'(bus.md_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
